// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Digit-serial two's-complement adder/subtractor. Each operation consumes
//   DIGIT bits per clock, least significant digit first, and finishes after
//   N = WIDTH/DIGIT clocks. Subtraction is performed as x + ~y + 1.
//   The operands and the mode are captured when start is accepted.
//   The result and flags are registered, and they are held until the next
//   completion.
//
// Parameters
//   WIDTH  operand/result width in bits (>= 2)
//   DIGIT  bits processed per clock; must divide WIDTH
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous reset, active-high
//   start  operation request, sampled only while idle
//   k      mode: 0 = x + y, 1 = x - y (captured with start)
//   x, y   operands (captured with start)
//   busy   operation in progress
//   done   one-cycle completion pulse
//   s      result modulo 2^WIDTH
//   cout   carry out of the MSB (subtract: 1 = no borrow)
//   ovf    signed overflow
//   zero   result is zero
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             k,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg;      // operand A, shifted right one digit per clock
    logic [WIDTH-1:0] b_reg;      // operand B (already inverted for subtract)
    logic [WIDTH-1:0] acc;        // partial result, filled from the top
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;       // digit sum with its carry out in the top bit
    logic [WIDTH-1:0] acc_shift;  // acc after the current digit enters at the top
    logic             last_digit;
    logic             msb_cin;

    // Digit adder. On the final digit, bit DIGIT-1 of the operands is the
    // word MSB, so its carry-in can be recovered as sum ^ a ^ b.
    always_comb begin
        dsum       = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, carry};
        msb_cin    = dsum[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
        last_digit = (cnt == LAST);
    end

    generate
        if (DIGIT == WIDTH) begin : g_acc_full
            assign acc_shift = dsum[DIGIT-1:0];
        end else begin : g_acc_shift
            assign acc_shift = {dsum[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values that were present before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next receives its default before the case statement. This
    // prevents the synthesis tool from inferring a latch on any path that
    // does not assign it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = RUN;
            RUN:     if (last_digit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= x;
                        b_reg <= k ? ~y : y;
                        carry <= k;          // the +1 of the two's-complement negation
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    acc   <= acc_shift;
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    carry <= dsum[DIGIT];
                    cnt   <= cnt + 1'b1;
                    if (last_digit) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        s    <= acc_shift;
                        cout <= dsum[DIGIT];
                        ovf  <= msb_cin ^ dsum[DIGIT];
                        zero <= (acc_shift == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst;

    // WIDTH=8, DIGIT=1 instance
    logic       start8, k8;
    logic [7:0] x8, y8, s8;
    logic       busy8, done8, cout8, ovf8, zero8;

    // WIDTH=16, DIGIT=4 instance
    logic        start16, k16;
    logic [15:0] x16, y16, s16;
    logic        busy16, done16, cout16, ovf16, zero16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .k(k8), .x(x8), .y(y8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .k(k16), .x(x16), .y(y16),
        .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16), .zero(zero16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    // Whole-word arithmetic: x + (k ? -y : y) with w-bit wrap-around.
    // Signed overflow uses the sign rule: both addends share a sign that
    // differs from the sign of the result.
    function automatic res_t model(input int w, input logic [15:0] xv,
                                   input logic [15:0] yv, input logic kv);
        res_t r;
        logic [31:0] mask, addend, full, xe;
        mask   = (32'd1 << w) - 32'd1;
        xe     = {16'h0, xv};
        addend = kv ? (~{16'h0, yv}) & mask : {16'h0, yv};
        full   = xe + addend + {31'd0, kv};
        r.s    = 16'(full & mask);
        r.cout = full[w];
        r.zero = ((full & mask) == 32'd0);
        r.ovf  = (xe[w-1] == addend[w-1]) && (full[w-1] != xe[w-1]);
        return r;
    endfunction

    logic m8_busy, m8_done, m16_busy, m16_done;
    int   m8_cnt, m16_cnt;
    res_t m8_res, m8_pend, m16_res, m16_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_busy <= 1'b0; m8_done <= 1'b0; m8_cnt <= 0; m8_res <= '0; m8_pend <= '0;
        end else begin
            m8_done <= 1'b0;
            if (!m8_busy) begin
                if (start8) begin
                    m8_busy <= 1'b1;
                    m8_cnt  <= 8;
                    m8_pend <= model(8, {8'h0, x8}, {8'h0, y8}, k8);
                end
            end else if (m8_cnt == 1) begin
                m8_busy <= 1'b0;
                m8_done <= 1'b1;
                m8_res  <= m8_pend;
            end else begin
                m8_cnt <= m8_cnt - 1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m16_busy <= 1'b0; m16_done <= 1'b0; m16_cnt <= 0; m16_res <= '0; m16_pend <= '0;
        end else begin
            m16_done <= 1'b0;
            if (!m16_busy) begin
                if (start16) begin
                    m16_busy <= 1'b1;
                    m16_cnt  <= 4;
                    m16_pend <= model(16, x16, y16, k16);
                end
            end else if (m16_cnt == 1) begin
                m16_busy <= 1'b0;
                m16_done <= 1'b1;
                m16_res  <= m16_pend;
            end else begin
                m16_cnt <= m16_cnt - 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("busy8", busy8, m8_busy);
        check("done8", done8, m8_done);
        check("s8",    s8,    m8_res.s[7:0]);
        check("cout8", cout8, m8_res.cout);
        check("ovf8",  ovf8,  m8_res.ovf);
        check("zero8", zero8, m8_res.zero);
        check("busy16", busy16, m16_busy);
        check("done16", done16, m16_done);
        check("s16",    s16,    m16_res.s);
        check("cout16", cout16, m16_res.cout);
        check("ovf16",  ovf16,  m16_res.ovf);
        check("zero16", zero16, m16_res.zero);
    end

    // ---------------- stimulus ----------------
    // Called just after a falling edge. The task returns at the falling edge
    // where done is seen, so a following call starts in the done cycle.
    // If disturb > 0, a junk start pulse with altered operands is issued at
    // that RUN cycle.
    task automatic op8(input logic kk, input logic [7:0] xx, input logic [7:0] yy,
                       input int disturb, output int lat);
        k8 = kk; x8 = xx; y8 = yy; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            if (lat + 1 == disturb) begin
                start8 = 1'b1; k8 = ~kk; x8 = ~xx; y8 = xx;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        check("op8_done_seen", done8, 1'b1);
    endtask

    task automatic op16(input logic kk, input logic [15:0] xx, input logic [15:0] yy,
                        output int lat);
        k16 = kk; x16 = xx; y16 = yy; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("op16_done_seen", done16, 1'b1);
    endtask

    initial begin
        int lat;
        int done_cnt;
        rst = 1'b1;
        start8 = 1'b0; k8 = 1'b0; x8 = '0; y8 = '0;
        start16 = 1'b0; k16 = 1'b0; x16 = '0; y16 = '0;
        @(negedge clk);
        check("rst_busy8", busy8, 1'b0);
        check("rst_s8", s8, 8'h00);
        check("rst_zero8", zero8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic add, latency N
        op8(1'b0, 8'h37, 8'h2C, 0, lat);
        check("t1_lat", lat, 8);
        check("t1_s", s8, 8'h63);
        check("t1_flags", {cout8, ovf8, zero8}, 3'b000);
        @(negedge clk);

        // 2: subtract with and without borrow
        op8(1'b1, 8'h0B, 8'h04, 0, lat);
        check("t2a_s", s8, 8'h07);
        check("t2a_cout", cout8, 1'b1);
        @(negedge clk);
        op8(1'b1, 8'h04, 8'h0B, 0, lat);
        check("t2b_s", s8, 8'hF9);
        check("t2b_flags", {cout8, ovf8, zero8}, 3'b000);
        @(negedge clk);

        // 3: signed overflow both ways
        op8(1'b0, 8'h7F, 8'h01, 0, lat);
        check("t3a_s", s8, 8'h80);
        check("t3a_flags", {cout8, ovf8}, 2'b01);
        @(negedge clk);
        op8(1'b1, 8'h80, 8'h01, 0, lat);
        check("t3b_s", s8, 8'h7F);
        check("t3b_flags", {cout8, ovf8}, 2'b11);
        @(negedge clk);

        // 4: zero result with a stray start at RUN cycle 3
        op8(1'b1, 8'h5A, 8'h5A, 3, lat);
        check("t4_lat", lat, 8);
        check("t4_s", s8, 8'h00);
        check("t4_flags", {cout8, ovf8, zero8}, 3'b101);
        repeat (3) @(negedge clk);
        check("t4_hold_zero", zero8, 1'b1);
        check("t4_hold_done", done8, 1'b0);

        // 5: reset in the middle of an operation
        k8 = 1'b0; x8 = 8'h11; y8 = 8'h22; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_busy", busy8, 1'b0);
        check("t5_s", s8, 8'h00);
        check("t5_flags", {cout8, ovf8, zero8}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) done_cnt++;
        end
        check("t5_no_done", done_cnt, 0);
        op8(1'b0, 8'h11, 8'h22, 0, lat);
        check("t5_fresh_lat", lat, 8);
        check("t5_fresh_s", s8, 8'h33);
        @(negedge clk);

        // 6: WIDTH=16, DIGIT=4 wrap-around, then start in the done cycle
        op16(1'b0, 16'hFFFF, 16'h0001, lat);
        check("t6_lat", lat, 4);
        check("t6_s", s16, 16'h0000);
        check("t6_flags", {cout16, ovf16, zero16}, 3'b101);
        op16(1'b0, 16'h1234, 16'h0FF0, lat);
        check("t6b_lat", lat, 4);
        check("t6b_s", s16, 16'h2224);
        check("t6b_flags", {cout16, ovf16, zero16}, 3'b000);
        @(negedge clk);
        op16(1'b1, 16'h8000, 16'h0001, lat);
        check("t6c_s", s16, 16'h7FFF);
        check("t6c_flags", {cout16, ovf16, zero16}, 3'b110);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
